// File: rtl/dec_rf_pkg.sv
// Shared definitions for the decode-stage multi-port register file.
package dec_rf_pkg;

    typedef enum int {
        WB_ALU = 0,
        WB_FPU = 1
    } wb_port_e;

    localparam int ZERO_IDX = 0;

    function automatic int aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dec_rf_wr_mux.sv
// Per-register write select: highest matching write port wins.
module dec_rf_wr_mux
    import dec_rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2,
    parameter int IDX  = 0
) (
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [XLEN-1:0]     q,
    output logic                en,
    output logic [XLEN-1:0]     din
);

    // din defaults to q so a scan-forced enable reloads the held value
    always_comb begin
        en  = 1'b0;
        din = q;
        for (int p = WB_ALU; p < NWR; p++) begin
            if (wen[p] && waddr[p*AW +: AW] == AW'(IDX)) begin
                en  = 1'b1;
                din = wd[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/dec_regfile_mp_ctl.sv
// Multi-port GPR/FPR file with write bypass and issue scoreboard.
module dec_regfile_mp_ctl
    import dec_rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_REG   = 0,
    localparam int AW      = aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rden,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec,
    input  logic                scan_mode
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] busy_nxt;

    function automatic logic [XLEN:0] fwd(
        input logic [AW-1:0]       a,
        input logic [NWR-1:0]      we,
        input logic [NWR*AW-1:0]   wa,
        input logic [NWR*XLEN-1:0] d
    );
        logic [XLEN:0] r;
        r = '0;
        for (int p = 0; p < NWR; p++) begin
            if (we[p] && wa[p*AW +: AW] == a) begin
                r = {1'b1, d[p*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    for (genvar n = 0; n < NREGS; n++) begin : g_reg
        if (ZERO_REG != 0 && n == ZERO_IDX) begin : g_zero
            assign regs[n] = '0;
        end else begin : g_ent
            logic            en;
            logic [XLEN-1:0] din;
            logic [XLEN-1:0] q;

            dec_rf_wr_mux #(
                .XLEN (XLEN),
                .AW   (AW),
                .NWR  (NWR),
                .IDX  (n)
            ) u_mux (
                .wen   (wen),
                .waddr (waddr),
                .wd    (wd),
                .q     (q),
                .en    (en),
                .din   (din)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (en | scan_mode) begin
                    q <= din;
                end
            end

            assign regs[n] = q;
        end
    end

    always_comb begin
        clr = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wen[p]) begin
                clr[waddr[p*AW +: AW]] = 1'b1;
            end
        end
    end

    // a new producer issued in the same cycle outranks the retiring write
    always_comb begin
        busy_nxt = busy & ~clr;
        if (iss_en) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[ZERO_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN:0]   f;
        logic [XLEN-1:0] val;
        logic            bsy;

        assign a = raddr[i*AW +: AW];
        assign f = fwd(a, wen, waddr, wd);

        always_comb begin
            val = regs[a];
            if (BYPASS != 0 && f[XLEN]) begin
                val = f[XLEN-1:0];
            end
            if (rst || !rden[i] || (ZERO_REG != 0 && a == AW'(ZERO_IDX))) begin
                val = '0;
            end
        end

        assign bsy = !rst && rden[i] && busy[a] && !(BYPASS != 0 && clr[a]);

        if (RD_REG != 0) begin : g_q
            logic [XLEN-1:0] val_q;
            logic            bsy_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    val_q <= '0;
                    bsy_q <= 1'b0;
                end else begin
                    val_q <= val;
                    bsy_q <= bsy;
                end
            end

            assign rd[i*XLEN +: XLEN] = val_q;
            assign rd_busy[i]         = bsy_q;
        end else begin : g_c
            assign rd[i*XLEN +: XLEN] = val;
            assign rd_busy[i]         = bsy;
        end
    end

endmodule

// File: tb/tb_dec_regfile_mp_ctl.sv
// Bench: directed steps then random traffic against an array model.
module tb_dec_regfile_mp_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rden;
    logic [14:0] raddr;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wd;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        scan_mode;

    logic [95:0] rd_a, rd_b;
    logic [2:0]  rb_a, rb_b;
    logic [31:0] bv_a, bv_b;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    logic [31:0] pend_rd [3];
    logic        pend_rb [3];

    always #5 clk = ~clk;

    dec_regfile_mp_ctl u_a (
        .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rd(rd_a),
        .rd_busy(rb_a), .wen(wen), .waddr(waddr), .wd(wd),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv_a),
        .scan_mode(scan_mode)
    );

    dec_regfile_mp_ctl #(.RD_REG(1)) u_b (
        .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rd(rd_b),
        .rd_busy(rb_b), .wen(wen), .waddr(waddr), .wd(wd),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(bv_b),
        .scan_mode(scan_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int i);
        logic [4:0]  a;
        logic [31:0] v;
        a = raddr[i*5 +: 5];
        if (rst || !rden[i] || a == 5'd0) return 32'h0;
        v = m_reg[a];
        for (int p = 0; p < 2; p++)
            if (wen[p] && waddr[p*5 +: 5] == a) v = wd[p*32 +: 32];
        return v;
    endfunction

    function automatic logic exp_rb(input int i);
        logic [4:0] a;
        a = raddr[i*5 +: 5];
        if (rst || !rden[i]) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (wen[p] && waddr[p*5 +: 5] == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_step();
        logic [4:0] a;
        if (rst) begin
            for (int n = 0; n < 32; n++) m_reg[n] = 32'h0;
            m_busy = 32'h0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = waddr[p*5 +: 5];
                if (wen[p] && a != 5'd0) m_reg[a] = wd[p*32 +: 32];
                if (wen[p]) m_busy[a] = 1'b0;
            end
            if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pend_rd[i] = exp_rd(i);
            pend_rb[i] = exp_rb(i);
            chk($sformatf("rd%0d", i), rd_a[i*32 +: 32], pend_rd[i]);
            chk($sformatf("rd_busy%0d", i), {31'h0, rb_a[i]}, {31'h0, pend_rb[i]});
        end
        @(posedge clk);
        #1;
        model_step();
        chk("busy_vec", bv_a, m_busy);
        chk("busy_vec_q", bv_b, m_busy);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rdq%0d", i), rd_b[i*32 +: 32], pend_rd[i]);
            chk($sformatf("rd_busyq%0d", i), {31'h0, rb_b[i]}, {31'h0, pend_rb[i]});
        end
    endtask

    task automatic idle();
        rst = 0; rden = '0; raddr = '0; wen = '0; waddr = '0; wd = '0;
        iss_en = 0; iss_addr = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wen[p] = 1'b1;
        waddr[p*5 +: 5] = a;
        wd[p*32 +: 32] = d;
    endtask

    task automatic rdp(input int i, input logic [4:0] a);
        rden[i] = 1'b1;
        raddr[i*5 +: 5] = a;
    endtask

    initial begin
        scan_mode = 0;
        m_busy = '0;
        for (int n = 0; n < 32; n++) m_reg[n] = '0;
        idle();
        rst = 1; wen = 2'b11; waddr = {5'd2, 5'd1}; wd = {2{32'hFFFFFFFF}};
        rden = 3'b111; raddr = {5'd2, 5'd1, 5'd5};
        #1;
        chk("rst_rd_comb", rd_a[31:0], 32'h0);
        cycle();
        cycle();
        idle(); rdp(0, 5'd5);
        #1 chk("r5_after_rst", rd_a[31:0], 32'h0);
        cycle();

        idle(); wr(0, 5'd5, 32'hDEADBEEF); cycle();
        idle(); rdp(0, 5'd5);
        #1 chk("r5_read", rd_a[31:0], 32'hDEADBEEF);
        cycle();
        idle(); wr(0, 5'd0, 32'h1234); cycle();
        idle(); rdp(0, 5'd0);
        #1 chk("r0_zero", rd_a[31:0], 32'h0);
        cycle();

        idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rdp(2, 5'd7);
        #1 chk("bypass_r7", rd_a[95:64], 32'h22);
        cycle();
        idle(); rdp(2, 5'd7);
        #1 chk("r7_hi_wins", rd_a[95:64], 32'h22);
        cycle();

        idle(); iss_en = 1; iss_addr = 5'd9; cycle();
        chk("busy9_set", {31'h0, bv_a[9]}, 32'h1);
        idle(); rdp(1, 5'd9);
        #1 chk("rd_busy_r9", {31'h0, rb_a[1]}, 32'h1);
        cycle();
        idle(); rdp(1, 5'd9); wr(1, 5'd9, 32'h3F800000); cycle();
        chk("busy9_clr", {31'h0, bv_a[9]}, 32'h0);
        idle(); iss_en = 1; iss_addr = 5'd9; wr(1, 5'd9, 32'h1); cycle();
        chk("busy9_set_wins", {31'h0, bv_a[9]}, 32'h1);

        idle(); wr(0, 5'd3, 32'hA5A5); cycle();
        idle(); rdp(1, 5'd3);
        #1 chk("rdq_lat_n", rd_b[63:32], 32'h0);
        cycle();
        chk("rdq_lat_n1", rd_b[63:32], 32'hA5A5);

        idle(); iss_en = 1; iss_addr = 5'd4; cycle();
        idle(); iss_en = 1; iss_addr = 5'd6; cycle();
        idle(); rst = 1; wr(0, 5'd4, 32'h55); cycle();
        chk("busy_after_rst", bv_a, 32'h0);
        idle(); rdp(0, 5'd4);
        #1 chk("r4_after_rst", rd_a[31:0], 32'h0);
        cycle();

        for (int k = 0; k < 400; k++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            wen = 2'($urandom);
            waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 7) == 0) waddr = 10'($urandom);
            wd = {$urandom, $urandom};
            rden = 3'($urandom);
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7))};
            iss_en = ($urandom_range(0, 2) == 0);
            iss_addr = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
